// File: rtl/rtcl_p3s7_led_pattern.sv
// Multi-LED pattern generator: ms time base, per-LED blink/breathe/heartbeat lanes, valid/ready mode updates.
// Optional gamma-corrected BREATHE duty when RTCL_P3S7_LED_GAMMA_EN is defined.

module rtcl_p3s7_led_lane (
    input  logic       clk50,
    input  logic       reset,
    input  logic       tick,
    input  logic       apply,
    input  logic [2:0] new_mode,
    input  logic [7:0] pwm_cnt,
    output logic       led
);
    localparam logic [2:0] MODE_OFF        = 3'd0;
    localparam logic [2:0] MODE_ON         = 3'd1;
    localparam logic [2:0] MODE_BLINK_SLOW = 3'd2;
    localparam logic [2:0] MODE_BLINK_FAST = 3'd3;
    localparam logic [2:0] MODE_BREATHE    = 3'd4;
    localparam logic [2:0] MODE_HEARTBEAT  = 3'd5;

    // Encoded in sequence order so the FSM advances by increment and wraps OFF2 -> ON1.
    localparam logic [1:0] HB_ON1  = 2'd0;
    localparam logic [1:0] HB_OFF1 = 2'd1;
    localparam logic [1:0] HB_ON2  = 2'd2;
    localparam logic [1:0] HB_OFF2 = 2'd3;

    logic [2:0] mode_q, mode_d;
    logic [9:0] phase_q, phase_d;
    logic [1:0] hb_q, hb_d;
    logic       led_q, led_d;
    logic [9:0] hb_last;
    logic [7:0] bright;
    logic [7:0] duty;

    assign hb_last = (hb_q == HB_OFF2) ? 10'd699 : 10'd99;

    always_comb begin
        mode_d  = mode_q;
        phase_d = phase_q;
        hb_d    = hb_q;
        if (apply) begin
            mode_d  = new_mode;
            phase_d = 10'd0;
            hb_d    = HB_ON1;
        end else if (tick) begin
            case (mode_q)
                MODE_BLINK_SLOW: phase_d = (phase_q >= 10'd999) ? 10'd0 : phase_q + 10'd1;
                MODE_BLINK_FAST: phase_d = (phase_q >= 10'd249) ? 10'd0 : phase_q + 10'd1;
                MODE_HEARTBEAT: begin
                    if (phase_q >= hb_last) begin
                        phase_d = 10'd0;
                        hb_d    = hb_q + 2'd1;
                    end else begin
                        phase_d = phase_q + 10'd1;
                    end
                end
                default: phase_d = phase_q + 10'd1;
            endcase
        end
    end

    // Triangle brightness: rising over the first half period, 255-x mirror over the second.
    assign bright = phase_q[9] ? ~phase_q[8:1] : phase_q[8:1];

`ifdef RTCL_P3S7_LED_GAMMA_EN
    assign duty = 8'((16'(bright) * 16'(bright)) >> 8);
`else
    assign duty = bright;
`endif

    always_comb begin
        led_d = 1'b0;
        case (mode_q)
            MODE_OFF:        led_d = 1'b0;
            MODE_ON:         led_d = 1'b1;
            MODE_BLINK_SLOW: led_d = (phase_q < 10'd500);
            MODE_BLINK_FAST: led_d = (phase_q < 10'd125);
            MODE_BREATHE:    led_d = (pwm_cnt < duty);
            MODE_HEARTBEAT:  led_d = (hb_q == HB_ON1) || (hb_q == HB_ON2);
            default:         led_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            mode_q  <= MODE_OFF;
            phase_q <= 10'd0;
            hb_q    <= HB_ON1;
            led_q   <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            phase_q <= phase_d;
            hb_q    <= hb_d;
            led_q   <= led_d;
        end
    end

    assign led = led_q;
endmodule

module rtcl_p3s7_led_pattern #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1000,
    parameter int N_LED   = 2
) (
    input  logic               clk50,
    input  logic               reset,
    input  logic [3*N_LED-1:0] s_mode,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [N_LED-1:0]   led,
    output logic               tick
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0]      presc_q, presc_d;
    logic               tick_q, tick_d;
    logic [7:0]         pwm_q, pwm_d;
    logic               pend_q, pend_d;
    logic [3*N_LED-1:0] pend_mode_q, pend_mode_d;
    logic               accept;
    logic               apply;
    logic               presc_wrap;

    assign presc_wrap = (presc_q == PW'(DIV - 1));
    assign s_ready    = ~pend_q;
    assign accept     = s_valid & s_ready;
    // pend_q only rises after the accepting edge, so a tick coincident with acceptance never applies.
    assign apply      = tick_q & pend_q;

    always_comb begin
        presc_d     = presc_wrap ? '0 : presc_q + PW'(1);
        tick_d      = presc_wrap;
        pwm_d       = pwm_q + 8'd1;
        pend_d      = pend_q;
        pend_mode_d = pend_mode_q;
        if (apply) pend_d = 1'b0;
        if (accept) begin
            pend_d      = 1'b1;
            pend_mode_d = s_mode;
        end
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            presc_q     <= '0;
            tick_q      <= 1'b0;
            pwm_q       <= 8'd0;
            pend_q      <= 1'b0;
            pend_mode_q <= '0;
        end else begin
            presc_q     <= presc_d;
            tick_q      <= tick_d;
            pwm_q       <= pwm_d;
            pend_q      <= pend_d;
            pend_mode_q <= pend_mode_d;
        end
    end

    for (genvar i = 0; i < N_LED; i++) begin : g_lane
        rtcl_p3s7_led_lane u_lane (
            .clk50    (clk50),
            .reset    (reset),
            .tick     (tick_q),
            .apply    (apply),
            .new_mode (pend_mode_q[3*i +: 3]),
            .pwm_cnt  (pwm_q),
            .led      (led[i])
        );
    end

    assign tick = tick_q;
endmodule

// File: tb/tb_rtcl_p3s7_led_pattern.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a negedge monitor pops and compares them.
module tb_rtcl_p3s7_led_pattern;
    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int N_LED   = 2;

    logic       clk50 = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] s_mode = 6'd0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [1:0] led;
    logic       tick;

    always #5 clk50 = ~clk50;

    rtcl_p3s7_led_pattern #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .N_LED(N_LED)) dut (
        .clk50   (clk50),
        .reset   (reset),
        .s_mode  (s_mode),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .led     (led),
        .tick    (tick)
    );

    typedef struct {
        int    cyc;
        string name;
        int    l0;
        int    l1;
        int    tk;
        int    rd;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Cycle index relative to reset release; held at 0 while reset is asserted.
    always @(posedge clk50) cyc <= reset ? 0 : cyc + 1;

    function automatic void expect_at(int c, string nm, int l0, int l1, int tk, int rd);
        exp_t e;
        e.cyc = c; e.name = nm; e.l0 = l0; e.l1 = l1; e.tk = tk; e.rd = rd;
        sb.push_back(e);
    endfunction

    task automatic check_field(string nm, string fld, logic got, int exp_v);
        if (exp_v >= 0) begin
            n_checks++;
            if (got !== exp_v[0]) begin
                n_fail++;
                $display("FAIL %s %s @cyc %0d: got %b expected %0d", nm, fld, cyc, got, exp_v);
            end
        end
    endtask

    always @(negedge clk50) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s missed: due cyc %0d, now %0d", e.name, e.cyc, cyc);
            end else begin
                check_field(e.name, "led0", led[0], e.l0);
                check_field(e.name, "led1", led[1], e.l1);
                check_field(e.name, "tick", tick, e.tk);
                check_field(e.name, "s_ready", s_ready, e.rd);
            end
        end
    end

    task automatic wait_cyc(int n);
        while (cyc < n) @(negedge clk50);
    endtask

    task automatic drain(int budget);
        int k = 0;
        while (sb.size() > 0 && k < budget) begin
            @(negedge clk50);
            k++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain timeout: %0d expectations pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset(string nm);
        reset   = 1'b1;
        s_valid = 1'b0;
        @(negedge clk50);
        @(negedge clk50);
        expect_at(0, {nm, " reset"}, 0, 0, 0, 1);
        @(negedge clk50);
        @(negedge clk50);
        reset = 1'b0;
    endtask

    task automatic send(logic [5:0] m, int at);
        wait_cyc(at);
        s_mode  = m;
        s_valid = 1'b1;
        @(negedge clk50);
        s_valid = 1'b0;
    endtask

    initial begin
        // Idle time base
        do_reset("idle");
        expect_at(5,  "idle c5",   0, 0, 0, 1);
        expect_at(9,  "idle c9",  -1, -1, 0, -1);
        expect_at(10, "idle t10",  0, 0, 1, 1);
        expect_at(11, "idle c11", -1, -1, 0, -1);
        expect_at(19, "idle c19", -1, -1, 0, -1);
        expect_at(20, "idle t20", -1, -1, 1, -1);
        expect_at(21, "idle c21", -1, -1, 0, -1);
        expect_at(30, "idle t30",  0, 0, 1, 1);
        drain(100);

        // LED0 BLINK_SLOW, LED1 BLINK_FAST
        do_reset("blink");
        expect_at(3,     "blink pre",      -1, -1, -1, 1);
        expect_at(4,     "blink rdy_drop", -1, -1, -1, 0);
        expect_at(10,    "blink apply",    -1, -1, 1, 0);
        expect_at(11,    "blink rdy_back",  0, 0, 0, 1);
        expect_at(12,    "blink lit",       1, 1, -1, 1);
        expect_at(1261,  "blink f_last",    1, 1, -1, -1);
        expect_at(1262,  "blink f_dark",    1, 0, -1, -1);
        expect_at(2511,  "blink f_dlast",   1, 0, -1, -1);
        expect_at(2512,  "blink f_relit",   1, 1, -1, -1);
        expect_at(5011,  "blink s_last",    1, -1, -1, -1);
        expect_at(5012,  "blink s_dark",    0, -1, -1, -1);
        expect_at(10011, "blink s_dlast",   0, -1, -1, -1);
        expect_at(10012, "blink s_relit",   1, -1, -1, -1);
        send({3'd3, 3'd2}, 3);
        drain(20000);

        // HEARTBEAT on LED0
        do_reset("hb");
        expect_at(11,    "hb pre",    0, 0, -1, 1);
        expect_at(12,    "hb on1",    1, 0, -1, -1);
        expect_at(1011,  "hb on1_e",  1, -1, -1, -1);
        expect_at(1012,  "hb off1",   0, -1, -1, -1);
        expect_at(2011,  "hb off1_e", 0, -1, -1, -1);
        expect_at(2012,  "hb on2",    1, -1, -1, -1);
        expect_at(3011,  "hb on2_e",  1, -1, -1, -1);
        expect_at(3012,  "hb off2",   0, -1, -1, -1);
        expect_at(10011, "hb off2_e", 0, 0, -1, -1);
        expect_at(10012, "hb wrap",   1, -1, -1, -1);
        send({3'd0, 3'd5}, 3);
        drain(20000);

        // BREATHE on LED0, applied at tick 120; phase 256..257 spans cycles 2681..2700
        do_reset("breathe");
        expect_at(113,  "br accept", -1, -1, 0, 1);
        expect_at(200,  "br b_low",   0, 0, -1, -1);
`ifdef RTCL_P3S7_LED_GAMMA_EN
        expect_at(2683, "br pwm122",  0, -1, -1, -1);
        expect_at(2688, "br pwm127",  0, -1, -1, -1);
`else
        expect_at(2683, "br pwm122",  1, -1, -1, -1);
        expect_at(2688, "br pwm127",  1, -1, -1, -1);
`endif
        expect_at(2689, "br pwm128",  0, -1, -1, -1);
        expect_at(2695, "br pwm134",  0, 0, -1, -1);
        send({3'd0, 3'd4}, 113);
        drain(5000);

        // Accept on tick, ignore second set while busy; LED1 mode 6 acts as OFF
        do_reset("coinc");
        expect_at(10, "coinc tick",  -1, -1, 1, 1);
        expect_at(11, "coinc busy",  -1, -1, 0, 0);
        expect_at(14, "coinc busy2", -1, -1, -1, 0);
        expect_at(20, "coinc apply",  0, 0, 1, 0);
        expect_at(21, "coinc ready",  0, 0, 0, 1);
        expect_at(22, "coinc led",    1, 0, -1, 1);
        expect_at(40, "coinc hold",   1, 0, -1, 1);
        send({3'd6, 3'd1}, 10);
        wait_cyc(14);
        s_mode  = {3'd1, 3'd0};
        s_valid = 1'b1;
        @(negedge clk50);
        s_valid = 1'b0;
        drain(200);

        // Reset with a pending set discards it
        do_reset("rstpend");
        expect_at(4, "rstpend busy", -1, -1, -1, 0);
        send({3'd0, 3'd1}, 3);
        wait_cyc(6);
        drain(10);
        do_reset("rstpend2");
        expect_at(9,  "rstpend c9",  -1, -1, 0, -1);
        expect_at(10, "rstpend t10",  0, 0, 1, 1);
        expect_at(12, "rstpend c12",  0, 0, 0, 1);
        expect_at(25, "rstpend c25",  0, 0, -1, 1);
        drain(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
